mult_div_unit: RTL

Iterative multiply/divide unit with architectural HI/LO registers. It is the parametrised successor to the single-cycle multiply path and the separate HI/LO register pair. It sits in the Execute stage: operands come from the forwarding muxes (post-forward A/B), and `Busy` drives the pipeline stall logic. It adds signed/unsigned divide, multiply-accumulate/subtract, MTHI/MTLO, flush, and a configurable operand width.

---
 rtl/mdu_pkg.sv | 41 ++++
 rtl/mdu_divstep.sv | 22 ++
 rtl/mult_div_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared types for the iterative multiply/divide unit: op codes, FSM states,
// divide-by-zero fill value and op-class helpers.
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_MADD  = 4'd3,
        OP_MADDU = 4'd4,
        OP_MSUB  = 4'd5,
        OP_MSUBU = 4'd6,
        OP_DIV   = 4'd7,
        OP_DIVU  = 4'd8,
        OP_MTHI  = 4'd9,
        OP_MTLO  = 4'd10
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    // Replicated to WIDTH bits to form the divide-by-zero LO value.
    localparam logic DIV0_LO_BIT = 1'b1;

    function automatic logic is_muldiv_op(input op_e op);
        return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU,
                          OP_MSUB, OP_MSUBU, OP_DIV, OP_DIVU};
    endfunction

    function automatic logic is_signed_op(input op_e op);
        return op inside {OP_MULT, OP_MADD, OP_MSUB, OP_DIV};
    endfunction

    function automatic logic is_div_op(input op_e op);
        return op inside {OP_DIV, OP_DIVU};
    endfunction

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division step on unsigned magnitudes: shift in the next
// dividend bit, trial-subtract the divisor, keep the result if no borrow.
module mdu_divstep #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {rem_i, quo_i[WIDTH-1]};
    assign diff    = shifted - {1'b0, div_i};
    // Bit WIDTH of the difference is the borrow: remainder stays below divisor.
    assign rem_o   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_o   = {quo_i[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers, multiply-accumulate,
// MTHI/MTLO and pipeline flush.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [3:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    op_e                op_q, op_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] snap_q, snap_d;
    logic [WIDTH-1:0]   araw_q, araw_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    op_e                op_in;
    logic               sgn_in;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nx;
    logic [WIDTH-1:0]   rem_nx, quo_nx;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s;
    logic [2*WIDTH-1:0] result;

    assign op_in  = op_e'(Op);
    assign sgn_in = is_signed_op(op_in);
    assign mag_a  = (sgn_in && A[WIDTH-1]) ? -A : A;
    assign mag_b  = (sgn_in && B[WIDTH-1]) ? -B : B;

    // acc holds {upper partial product, multiplier} or {remainder, quotient}.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
    assign mul_nx  = {mul_sum, acc_q[WIDTH-1:1]};

    mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
        .rem_i (acc_q[2*WIDTH-1:WIDTH]),
        .quo_i (acc_q[WIDTH-1:0]),
        .div_i (m_q),
        .rem_o (rem_nx),
        .quo_o (quo_nx)
    );

    assign prod_s = neg_res_q ? -acc_q : acc_q;
    assign quo_s  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_s  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        result = prod_s;
        case (op_q)
            OP_MADD, OP_MADDU: result = snap_q + prod_s;
            OP_MSUB, OP_MSUBU: result = snap_q - prod_s;
            OP_DIV, OP_DIVU:   result = div0_q ? {araw_q, {WIDTH{DIV0_LO_BIT}}}
                                               : {rem_s, quo_s};
            default:           result = prod_s;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        m_d       = m_q;
        acc_d     = acc_q;
        snap_d    = snap_q;
        araw_d    = araw_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start && !Flush) begin
                    if (op_in == OP_MTHI) begin
                        hi_d   = A;
                        done_d = 1'b1;
                    end else if (op_in == OP_MTLO) begin
                        lo_d   = A;
                        done_d = 1'b1;
                    end else if (is_muldiv_op(op_in)) begin
                        state_d   = ST_RUN;
                        cnt_d     = CW'(WIDTH);
                        op_d      = op_in;
                        snap_d    = {hi_q, lo_q};
                        araw_d    = A;
                        neg_res_d = sgn_in && (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_rem_d = sgn_in && A[WIDTH-1];
                        div0_d    = (B == '0);
                        if (is_div_op(op_in)) begin
                            m_d   = mag_b;
                            acc_d = {{WIDTH{1'b0}}, mag_a};
                        end else begin
                            m_d   = mag_a;
                            acc_d = {{WIDTH{1'b0}}, mag_b};
                        end
                    end
                end
            end
            ST_RUN: begin
                if (Flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = is_div_op(op_q) ? {rem_nx, quo_nx} : mul_nx;
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                if (!Flush) begin
                    hi_d   = result[2*WIDTH-1:WIDTH];
                    lo_d   = result[WIDTH-1:0];
                    done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= OP_NOP;
            m_q       <= '0;
            acc_q     <= '0;
            snap_q    <= '0;
            araw_q    <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            snap_q    <= snap_d;
            araw_q    <= araw_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign Busy = (state_q != ST_IDLE);
    assign Done = done_q;
    assign Hi   = hi_q;
    assign Lo   = lo_q;

endmodule
